// File: rtl/ioctl_pkg.sv
// Shared definitions for the ioctl download sender: state encoding and
// default sizing of the address counter and the gap/tail timers.
package ioctl_pkg;

   localparam int ADDR_W_DEF      = 25;
   localparam int GAP_CYCLES_DEF  = 2;
   localparam int TAIL_CYCLES_DEF = 4;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_FETCH  = 3'd2,
      ST_WRITE  = 3'd3,
      ST_GAP    = 3'd4,
      ST_HOLD   = 3'd5,
      ST_FINISH = 3'd6
   } state_e;

endpackage

// File: rtl/ioctl_sender_if.sv
// ioctl download bus between the sender (master) and the receiving core (slave).
interface ioctl_sender_if
   import ioctl_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF
);

   logic              ioctl_download;
   logic              ioctl_wr;
   logic [ADDR_W-1:0] ioctl_addr;
   logic [7:0]        ioctl_dout;
   logic [7:0]        ioctl_index;
   logic              ioctl_wait;

   modport master (
      output ioctl_download,
      output ioctl_wr,
      output ioctl_addr,
      output ioctl_dout,
      output ioctl_index,
      input  ioctl_wait
   );

   modport slave (
      input  ioctl_download,
      input  ioctl_wr,
      input  ioctl_addr,
      input  ioctl_dout,
      input  ioctl_index,
      output ioctl_wait
   );

endinterface

// File: rtl/ioctl_sender.sv
// Streams a byte source onto the ioctl download bus with paced write strobes.
// Optional build macro IOCTL_SENDER_CHECKSUM_EN adds a 16-bit sum of written bytes.
//
// state  | meaning
// IDLE   | waiting for start
// START  | download window opens, one cycle
// FETCH  | src_ready high, waiting for a source byte
// WRITE  | one-cycle ioctl_wr strobe
// GAP    | GAP_CYCLES idle cycles after a strobe
// HOLD   | receiver asserted ioctl_wait, stalled
// FINISH | TAIL_CYCLES with the window still open, then done
module ioctl_sender
   import ioctl_pkg::*;
#(
   parameter int ADDR_W      = ADDR_W_DEF,
   parameter int GAP_CYCLES  = GAP_CYCLES_DEF,
   parameter int TAIL_CYCLES = TAIL_CYCLES_DEF
) (
   input  logic              clk_sys,
   input  logic              reset_n,
   input  logic              start,
   input  logic [7:0]        index,
   input  logic [ADDR_W-1:0] length,
   input  logic              abort,
   input  logic [7:0]        src_data,
   input  logic              src_valid,
   output logic              src_ready,
   output logic              busy,
   output logic              done,
`ifdef IOCTL_SENDER_CHECKSUM_EN
   output logic [15:0]       checksum,
`endif
   ioctl_sender_if.master    ioctl
);

   localparam logic [7:0] GAP_LOAD  = 8'(GAP_CYCLES - 1);
   localparam logic [7:0] TAIL_LOAD = 8'(TAIL_CYCLES - 1);

   state_e            state_q, state_d;
   logic [7:0]        tmr_q, tmr_d;
   logic [ADDR_W-1:0] cnt_q, cnt_d;
   logic [ADDR_W-1:0] len_q, len_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [7:0]        dout_q, dout_d;
   logic [7:0]        index_q, index_d;
   logic              active_q, active_d;
   logic              wr_q, wr_d;
   logic              src_ready_q, src_ready_d;
   logic              done_q, done_d;
   logic              handshake;
   state_e            resume_st;

   assign handshake = src_valid & src_ready_q;
   assign resume_st = (cnt_q == len_q) ? ST_FINISH : ST_FETCH;

   always_comb begin
      state_d = state_q;
      tmr_d   = tmr_q;
      cnt_d   = cnt_q;
      len_d   = len_q;
      addr_d  = addr_q;
      dout_d  = dout_q;
      index_d = index_q;
      done_d  = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = ST_START;
               index_d = index;
               len_d   = length;
               cnt_d   = '0;
            end
         end
         ST_START: begin
            state_d = (abort || len_q == '0) ? ST_FINISH : ST_FETCH;
         end
         ST_FETCH: begin
            // abort beats a simultaneous handshake; that byte is dropped
            if (abort) begin
               state_d = ST_FINISH;
            end else if (handshake) begin
               state_d = ST_WRITE;
               addr_d  = cnt_q;
               dout_d  = src_data;
            end
         end
         ST_WRITE: begin
            cnt_d   = cnt_q + ADDR_W'(1);
            state_d = abort ? ST_FINISH : ST_GAP;
         end
         ST_GAP: begin
            if (abort) begin
               state_d = ST_FINISH;
            end else if (tmr_q == 8'd0) begin
               state_d = ioctl.ioctl_wait ? ST_HOLD : resume_st;
            end else begin
               tmr_d = tmr_q - 8'd1;
            end
         end
         ST_HOLD: begin
            if (abort) begin
               state_d = ST_FINISH;
            end else if (!ioctl.ioctl_wait) begin
               state_d = resume_st;
            end
         end
         ST_FINISH: begin
            if (tmr_q == 8'd0) begin
               state_d = ST_IDLE;
               done_d  = 1'b1;
            end else begin
               tmr_d = tmr_q - 8'd1;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // the single down-counter is reloaded on entry to whichever timed state follows
      if (state_d == ST_GAP && state_q != ST_GAP) begin
         tmr_d = GAP_LOAD;
      end
      if (state_d == ST_FINISH && state_q != ST_FINISH) begin
         tmr_d = TAIL_LOAD;
      end

      active_d    = (state_d != ST_IDLE);
      wr_d        = (state_d == ST_WRITE);
      src_ready_d = (state_d == ST_FETCH);
   end

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= ST_IDLE;
         tmr_q       <= 8'd0;
         cnt_q       <= '0;
         len_q       <= '0;
         addr_q      <= '0;
         dout_q      <= 8'd0;
         index_q     <= 8'd0;
         active_q    <= 1'b0;
         wr_q        <= 1'b0;
         src_ready_q <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         tmr_q       <= tmr_d;
         cnt_q       <= cnt_d;
         len_q       <= len_d;
         addr_q      <= addr_d;
         dout_q      <= dout_d;
         index_q     <= index_d;
         active_q    <= active_d;
         wr_q        <= wr_d;
         src_ready_q <= src_ready_d;
         done_q      <= done_d;
      end
   end

`ifdef IOCTL_SENDER_CHECKSUM_EN
   logic [15:0] csum_q, csum_d;

   always_comb begin
      csum_d = csum_q;
      if (state_q == ST_IDLE && start) begin
         csum_d = 16'd0;
      end else if (state_q == ST_WRITE) begin
         csum_d = csum_q + {8'h00, dout_q};
      end
   end

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         csum_q <= 16'd0;
      end else begin
         csum_q <= csum_d;
      end
   end

   assign checksum = csum_q;
`endif

   assign src_ready            = src_ready_q;
   assign busy                 = active_q;
   assign done                 = done_q;
   assign ioctl.ioctl_download = active_q;
   assign ioctl.ioctl_wr       = wr_q;
   assign ioctl.ioctl_addr     = addr_q;
   assign ioctl.ioctl_dout     = dout_q;
   assign ioctl.ioctl_index    = index_q;

endmodule

// File: tb/tb_ioctl_sender.sv
// Directed bench for ioctl_sender: table of plain transfers plus hand-written
// back-pressure, abort and reset sequences.
`timescale 1ns/1ps
module tb_ioctl_sender;
   import ioctl_pkg::*;

   localparam int AW = ADDR_W_DEF;

   logic          clk_sys   = 1'b0;
   logic          reset_n   = 1'b0;
   logic          start     = 1'b0;
   logic          abort     = 1'b0;
   logic          src_valid = 1'b0;
   logic [7:0]    index     = 8'h00;
   logic [7:0]    src_data  = 8'h00;
   logic [AW-1:0] length    = '0;
   logic          src_ready, busy, done;
`ifdef IOCTL_SENDER_CHECKSUM_EN
   logic [15:0]   checksum;
`endif

   ioctl_sender_if #(.ADDR_W(AW)) ioctl ();

   ioctl_sender #(.ADDR_W(AW), .GAP_CYCLES(2), .TAIL_CYCLES(4)) dut (
      .clk_sys   (clk_sys),
      .reset_n   (reset_n),
      .start     (start),
      .index     (index),
      .length    (length),
      .abort     (abort),
      .src_data  (src_data),
      .src_valid (src_valid),
      .src_ready (src_ready),
      .busy      (busy),
      .done      (done),
`ifdef IOCTL_SENDER_CHECKSUM_EN
      .checksum  (checksum),
`endif
      .ioctl     (ioctl)
   );

   always #5 clk_sys = ~clk_sys;

   int n_checks = 0;
   int n_err    = 0;

   int            cyc = 0, wr_cnt = 0, done_cnt = 0, hs_cnt = 0, dl_cnt = 0, idx_bad = 0, done_cyc = 0;
   int            wr_cyc [16];
   logic [AW-1:0] wr_addr[16];
   logic [7:0]    wr_dout[16];
   logic [7:0]    exp_index = 8'h00;
   logic [7:0]    src_b0    = 8'h00;

   typedef struct {
      int         len;
      logic [7:0] idx;
      logic [7:0] b0;
      int         exp_wr;
      int         exp_dl;
      logic [15:0] exp_csum;
   } vec_t;

   vec_t vecs[4];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // bus monitor, sampled on the falling edge
   initial begin
      forever begin
         @(negedge clk_sys);
         cyc++;
         if (ioctl.ioctl_wr) begin
            if (wr_cnt < 16) begin
               wr_cyc[wr_cnt]  = cyc;
               wr_addr[wr_cnt] = ioctl.ioctl_addr;
               wr_dout[wr_cnt] = ioctl.ioctl_dout;
            end
            wr_cnt++;
         end
         if (done) begin
            done_cnt++;
            done_cyc = cyc;
         end
         if (src_valid && src_ready) hs_cnt++;
         if (ioctl.ioctl_download) begin
            dl_cnt++;
            if (ioctl.ioctl_index !== exp_index) idx_bad++;
         end
      end
   end

   // source stream: byte k of a transfer is src_b0 + k
   initial begin
      forever begin
         @(posedge clk_sys);
         #1;
         src_data = src_b0 + 8'(hs_cnt);
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   task automatic start_xfer(input int len, input logic [7:0] idx, input logic [7:0] b0);
      @(posedge clk_sys);
      #1;
      wr_cnt = 0; done_cnt = 0; hs_cnt = 0; dl_cnt = 0; idx_bad = 0; done_cyc = 0;
      src_b0 = b0; exp_index = idx; src_data = b0;
      start = 1'b1; index = idx; length = AW'(len);
      @(posedge clk_sys);
      #1;
      start = 1'b0; index = ~idx; length = '1;
   endtask

   task automatic wait_wr(input int n, input int budget);
      int k = 0;
      while (wr_cnt < n && k < budget) begin
         @(negedge clk_sys);
         #2;
         k++;
      end
      check("wait_for_write", 32'(wr_cnt >= n), 1);
   endtask

   task automatic wait_done(input int budget);
      int k = 0;
      while (done_cnt == 0 && k < budget) begin
         @(negedge clk_sys);
         #2;
         k++;
      end
      check("wait_for_done", 32'(done_cnt != 0), 1);
      repeat (5) @(negedge clk_sys);
      #2;
   endtask

   task automatic check_outputs_zero(input string tag);
      check({tag, "_download"}, 32'(ioctl.ioctl_download), 0);
      check({tag, "_wr"},       32'(ioctl.ioctl_wr), 0);
      check({tag, "_src_ready"}, 32'(src_ready), 0);
      check({tag, "_busy"},     32'(busy), 0);
      check({tag, "_done"},     32'(done), 0);
      check({tag, "_addr"},     32'(ioctl.ioctl_addr), 0);
      check({tag, "_dout"},     32'(ioctl.ioctl_dout), 0);
      check({tag, "_index"},    32'(ioctl.ioctl_index), 0);
   endtask

   initial begin
      logic [7:0] eb;
      int         last;
      int         held_bad;

      ioctl.ioctl_wait = 1'b0;
      vecs[0] = '{4, 8'h03, 8'hA0, 4, 21, 16'h0286};
      vecs[1] = '{0, 8'h11, 8'h00, 0,  5, 16'h0000};
      vecs[2] = '{1, 8'hFF, 8'h7F, 1,  9, 16'h007F};
      vecs[3] = '{3, 8'h5A, 8'hFE, 3, 17, 16'h01FD};

      repeat (3) @(negedge clk_sys);
      #2;
      check_outputs_zero("reset");
      @(negedge clk_sys);
      reset_n = 1'b1;

      for (int v = 0; v < 4; v++) begin
         src_valid = 1'b1;
         start_xfer(vecs[v].len, vecs[v].idx, vecs[v].b0);
         wait_done(300);
         check($sformatf("v%0d_writes", v), wr_cnt, vecs[v].exp_wr);
         check($sformatf("v%0d_done_count", v), done_cnt, 1);
         check($sformatf("v%0d_download_cycles", v), dl_cnt, vecs[v].exp_dl);
         check($sformatf("v%0d_index_stable", v), idx_bad, 0);
         check($sformatf("v%0d_busy_after", v), 32'(busy), 0);
         for (int i = 0; i < wr_cnt && i < 16; i++) begin
            eb = vecs[v].b0 + 8'(i);
            check($sformatf("v%0d_addr%0d", v, i), 32'(wr_addr[i]), i);
            check($sformatf("v%0d_dout%0d", v, i), 32'(wr_dout[i]), 32'(eb));
            if (i > 0) check($sformatf("v%0d_period%0d", v, i), wr_cyc[i] - wr_cyc[i-1], 4);
         end
         if (wr_cnt > 0 && wr_cnt <= 16) begin
            last = wr_cnt - 1;
            check($sformatf("v%0d_done_latency", v), done_cyc - wr_cyc[last], 7);
         end
`ifdef IOCTL_SENDER_CHECKSUM_EN
         check($sformatf("v%0d_checksum", v), 32'(checksum), 32'(vecs[v].exp_csum));
`endif
      end

      // receiver back-pressure after the first write
      src_valid = 1'b1;
      start_xfer(2, 8'h21, 8'h30);
      wait_wr(1, 50);
      ioctl.ioctl_wait = 1'b1;
      held_bad = 0;
      repeat (10) begin
         @(negedge clk_sys);
         #2;
         if (ioctl.ioctl_addr !== '0 || wr_cnt != 1) held_bad++;
      end
      ioctl.ioctl_wait = 1'b0;
      check("wait_hold_stable", held_bad, 0);
      check("wait_busy_in_hold", 32'(busy), 1);
      wait_done(100);
      check("wait_writes", wr_cnt, 2);
      check("wait_second_delay", wr_cyc[1] - wr_cyc[0], 12);
      check("wait_addr1", 32'(wr_addr[1]), 1);
      check("wait_dout1", 32'(wr_dout[1]), 32'h31);
      check("wait_done_count", done_cnt, 1);
`ifdef IOCTL_SENDER_CHECKSUM_EN
      check("wait_checksum", 32'(checksum), 32'h0061);
`endif

      // abort during GAP after the third write
      start_xfer(8, 8'h45, 8'h10);
      wait_wr(3, 100);
      @(posedge clk_sys);
      #1;
      abort = 1'b1;
      @(posedge clk_sys);
      #1;
      abort = 1'b0;
      wait_done(100);
      check("abort_gap_writes", wr_cnt, 3);
      check("abort_gap_handshakes", hs_cnt, 3);
      check("abort_gap_done_count", done_cnt, 1);
      check("abort_gap_done_latency", done_cyc - wr_cyc[2], 6);

      // abort during WRITE lets the strobe finish, then goes straight to FINISH
      start_xfer(8, 8'h46, 8'h50);
      wait_wr(2, 100);
      abort = 1'b1;
      @(posedge clk_sys);
      #1;
      abort = 1'b0;
      wait_done(100);
      check("abort_wr_writes", wr_cnt, 2);
      check("abort_wr_handshakes", hs_cnt, 2);
      check("abort_wr_done_latency", done_cyc - wr_cyc[1], 5);
      check("abort_wr_dout1", 32'(wr_dout[1]), 32'h51);

      // stalled FETCH, then abort together with a handshake
      src_valid = 1'b0;
      start_xfer(3, 8'h47, 8'h77);
      repeat (20) @(negedge clk_sys);
      #2;
      check("stall_src_ready", 32'(src_ready), 1);
      check("stall_no_write", wr_cnt, 0);
      @(posedge clk_sys);
      #1;
      src_valid = 1'b1;
      abort = 1'b1;
      @(posedge clk_sys);
      #1;
      abort = 1'b0;
      src_valid = 1'b0;
      wait_done(100);
      check("abort_hs_writes", wr_cnt, 0);
      check("abort_hs_handshakes", hs_cnt, 1);
      check("abort_hs_done_count", done_cnt, 1);

      // reset in FETCH mid-transfer, then a fresh transfer
      src_valid = 1'b1;
      start_xfer(5, 8'h48, 8'h90);
      wait_wr(2, 100);
      begin
         int k = 0;
         while (!src_ready && k < 20) begin
            @(negedge clk_sys);
            #2;
            k++;
         end
      end
      check("rst_in_fetch", 32'(src_ready), 1);
      reset_n = 1'b0;
      #1;
      check_outputs_zero("midrst");
      repeat (3) @(negedge clk_sys);
      #2;
      check("midrst_no_done", done_cnt, 0);
      reset_n = 1'b1;
      start_xfer(2, 8'h66, 8'hC0);
      wait_done(100);
      check("post_rst_writes", wr_cnt, 2);
      check("post_rst_addr0", 32'(wr_addr[0]), 0);
      check("post_rst_dout0", 32'(wr_dout[0]), 32'hC0);
      check("post_rst_addr1", 32'(wr_addr[1]), 1);
      check("post_rst_done_count", done_cnt, 1);
`ifdef IOCTL_SENDER_CHECKSUM_EN
      check("post_rst_checksum", 32'(checksum), 32'h0181);
`endif

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule

// File: doc/ioctl_sender.md
IOCTL_SENDER -- requirements
Module: ioctl_sender

Interface
REQ-001 Parameter ADDR_W, 25, width of ioctl_addr and length.
REQ-002 Parameter GAP_CYCLES, 2, idle cycles after each ioctl_wr pulse; legal range 1..255.
REQ-003 Parameter TAIL_CYCLES, 4, cycles ioctl_download stays high after the last write.
REQ-004 clk_sys  in  1  single system clock; all logic rising-edge.
REQ-005 reset_n  in  1  asynchronous, active-low reset.
REQ-006 start  in  1  one-cycle request; honoured only in IDLE.
REQ-007 index  in  8  download index, latched on accepted start.
REQ-008 length  in  ADDR_W  byte count, latched on accepted start.
REQ-009 abort  in  1  terminate the transfer early.
REQ-010 src_data  in  8  byte from the source stream.
REQ-011 src_valid  in  1  src_data is valid.
REQ-012 src_ready  out  1  byte consumed when src_valid and src_ready are both high.
REQ-013 ioctl_download  out  1  download window, high from START through FINISH.
REQ-014 ioctl_wr  out  1  one-cycle write strobe.
REQ-015 ioctl_addr  out  ADDR_W  byte address of the current write.
REQ-016 ioctl_dout  out  8  byte of the current write.
REQ-017 ioctl_index  out  8  latched index, held stable while ioctl_download is high.
REQ-018 ioctl_wait  in  1  receiver back-pressure; no new write while high.
REQ-019 busy  out  1  high in every state except IDLE.
REQ-020 done  out  1  one-cycle pulse on the FINISH-to-IDLE transition.

Function
REQ-021 States: IDLE, START, FETCH, WRITE, GAP, HOLD, FINISH.
REQ-022 IDLE: start=1 latches index and length, clears the byte counter, and moves to START; start in any other state is ignored.
REQ-023 START lasts one cycle with ioctl_download=1, then goes to FETCH, or to FINISH if length==0.
REQ-024 FETCH:
- src_ready=1 in this state only.
- A handshake captures src_data and moves to WRITE on the next cycle.
- With no handshake, the block stays in FETCH with no timeout.
REQ-025 WRITE lasts one cycle:
- ioctl_wr=1, ioctl_addr=counter, ioctl_dout=captured byte.
- Counter increments at the end of the cycle.
- Next state is GAP.
REQ-026 GAP counts GAP_CYCLES cycles, then:
- HOLD if ioctl_wait=1;
- else FINISH if counter==length;
- else FETCH.
REQ-027 HOLD stays while ioctl_wait=1; on ioctl_wait=0 it applies the same FINISH/FETCH decision as GAP.
REQ-028 ioctl_wait high outside GAP/HOLD has no effect, and an in-flight WRITE is never cancelled.
REQ-029 ioctl_addr and ioctl_dout hold their last written values between writes.
REQ-030 Minimum write period is 1+GAP_CYCLES+1 cycles with src_valid held high.
REQ-031 FINISH keeps ioctl_download=1 for TAIL_CYCLES cycles, then drops it, pulses done, and returns to IDLE.
REQ-032 abort=1 in START, FETCH, GAP or HOLD goes to FINISH next cycle with no further writes and no further source handshakes.
REQ-033 abort=1 in WRITE completes the strobe, then goes to FINISH; abort is ignored in IDLE and FINISH.
REQ-034 Simultaneous abort and src handshake in FETCH: abort wins and the byte is discarded, but it counts as consumed.
REQ-035 The counter is ADDR_W wide and does not wrap, since length is at most 2^ADDR_W-1.

Reset
REQ-036 reset_n=0 forces IDLE asynchronously and clears every output:
- ioctl_download, ioctl_wr, src_ready, busy, done = 0;
- ioctl_addr, ioctl_dout, ioctl_index = 0.
REQ-037 Reset mid-transfer abandons it immediately with no done pulse; the first start after reset release begins a fresh transfer.

Configuration
REQ-038 IOCTL_SENDER_CHECKSUM_EN defined:
- Adds output checksum (16 bits): the modulo-2^16 sum of every ioctl_dout value strobed by ioctl_wr in the current transfer.
- Cleared on accepted start and on reset; held after done.
REQ-039 IOCTL_SENDER_CHECKSUM_EN undefined: no checksum port and no adder logic.

Structure
REQ-040 Shared package ioctl_pkg holds the state enumeration, the default ADDR_W constant, and the GAP/TAIL defaults.
REQ-041 There is no sub-module; the GAP and FINISH counters share one 8-bit down-counter inside ioctl_sender.

Verification
REQ-042 length=4, index=0x03, src bytes A0..A3, src_valid always 1, ioctl_wait=0:
- four ioctl_wr pulses at addr 0..3 with dout A0..A3, each 4 cycles apart;
- done 4 cycles after the last GAP; checksum=0x0286.
REQ-043 length=2, ioctl_wait held high for 10 cycles after the first write -> second write is delayed until ioctl_wait falls; ioctl_addr stays 0 meanwhile.
REQ-044 length=0 -> ioctl_download high for 1+TAIL_CYCLES cycles, no ioctl_wr, done pulses once.
REQ-045 length=8, abort asserted in GAP after the third write -> exactly 3 writes, no src handshake afterwards, done pulses once.
REQ-046 reset_n pulsed low during FETCH of a length=5 transfer:
- all outputs go to 0 immediately, no done pulse;
- the next start writes from addr 0.
